exec_unit: RTL and testbench



---
 rtl/exec_unit_pkg.sv | 23 ++
 rtl/exec_unit_if.sv | 29 ++
 rtl/exec_alu.sv | 37 +++
 rtl/exec_unit.sv | 107 ++++++++++
 tb/tb_exec_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_unit_pkg.sv
// Shared constants for the integer execution unit: opcodes, datapath and tag widths.
package exec_unit_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int OP_W   = 5;
  localparam int OCC_W  = 3;

  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_AND = 5'd2,
    OP_OR  = 5'd3,
    OP_XOR = 5'd4,
    OP_SLL = 5'd5,
    OP_SRL = 5'd6,
    OP_SLT = 5'd7,
    OP_MUL = 5'd8
  } op_e;

endpackage

// File: rtl/exec_unit_if.sv
// Issue/CDB bundle between reservation station, CDB arbiter and exec_unit.
interface exec_unit_if;
  import exec_unit_pkg::*;

  logic              issue_en;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_data1;
  logic [DATA_W-1:0] issue_data2;
  logic [TAG_W-1:0]  issue_label;
  logic              exe_able;
  logic              cdb_req;
  logic              cdb_grant;
  logic              bc_en;
  logic [TAG_W-1:0]  bc_label;
  logic [DATA_W-1:0] bc_data;
  logic              bc_err;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output issue_en, issue_op, issue_data1, issue_data2, issue_label, cdb_grant,
    input  exe_able, cdb_req, bc_en, bc_label, bc_data, bc_err, occupancy
  );

  modport slave (
    input  issue_en, issue_op, issue_data1, issue_data2, issue_label, cdb_grant,
    output exe_able, cdb_req, bc_en, bc_label, bc_data, bc_err, occupancy
  );

endinterface

// File: rtl/exec_alu.sv
// Combinational integer ALU; the multiplier exists only when EXEC_MUL_EN is defined.
module exec_alu
  import exec_unit_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << b[4:0];
      OP_SRL:  result = a >> b[4:0];
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
`ifdef EXEC_MUL_EN
      OP_MUL:  result = a * b;
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Fixed-latency in-order execution pipeline with bubble-collapsing stalls and CDB handshake.
// Optional multiplier: define EXEC_MUL_EN.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  exec_unit_if.slave  bus
);

  logic [DATA_W-1:0] alu_res;
  logic              alu_err;
  logic              accept;

  logic [LATENCY:1]   vld_p;
  logic [LATENCY:1]   vld_nxt;
  logic [LATENCY:1]   take;
  logic [LATENCY-1:0] vld_src;
  logic [TAG_W-1:0]   lbl_p   [1:LATENCY];
  logic [DATA_W-1:0]  data_p  [1:LATENCY];
  logic               err_p   [1:LATENCY];
  logic [TAG_W-1:0]   lbl_src [0:LATENCY-1];
  logic [DATA_W-1:0]  data_src[0:LATENCY-1];
  logic               err_src [0:LATENCY-1];
  logic [OCC_W-1:0]   occ_q;
  logic [OCC_W-1:0]   occ_nxt;
  logic               full_tail;

  exec_alu u_alu (
    .op     (bus.issue_op),
    .a      (bus.issue_data1),
    .b      (bus.issue_data2),
    .result (alu_res),
    .err    (alu_err)
  );

  // A stage can take new contents when it or any stage downstream of it is empty,
  // or when the output is being granted this cycle.
  always_comb begin
    full_tail = 1'b1;
    take      = '0;
    for (int i = LATENCY; i >= 1; i--) begin
      full_tail = full_tail & vld_p[i];
      take[i]   = bus.cdb_grant | ~full_tail;
    end
  end

  assign accept = bus.issue_en & take[1] & (bus.issue_label != NO_TAG);

  // Stage 0: the freshly computed result feeds stage 1; stage i-1 feeds stage i.
  always_comb begin
    vld_src     = '0;
    vld_src[0]  = accept;
    lbl_src[0]  = bus.issue_label;
    data_src[0] = alu_res;
    err_src[0]  = alu_err;
    for (int i = 1; i < LATENCY; i++) begin
      vld_src[i]  = vld_p[i];
      lbl_src[i]  = lbl_p[i];
      data_src[i] = data_p[i];
      err_src[i]  = err_p[i];
    end
  end

  always_comb begin
    vld_nxt = vld_p;
    occ_nxt = '0;
    for (int i = 1; i <= LATENCY; i++) begin
      if (take[i]) vld_nxt[i] = vld_src[i-1];
      occ_nxt = occ_nxt + OCC_W'(vld_nxt[i]);
    end
  end

  // Stages 1..LATENCY: control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      occ_q <= '0;
    end else begin
      vld_p <= vld_nxt;
      occ_q <= occ_nxt;
    end
  end

  // Stages 1..LATENCY: payload, only loaded with valid entries so a stalled head stays stable
  always_ff @(posedge clk) begin
    for (int i = 1; i <= LATENCY; i++) begin
      if (take[i] && vld_src[i-1]) begin
        lbl_p[i]  <= lbl_src[i-1];
        data_p[i] <= data_src[i-1];
        err_p[i]  <= err_src[i-1];
      end
    end
  end

  // Output stage and CDB handshake
  assign bus.cdb_req   = vld_p[LATENCY];
  assign bus.bc_en     = vld_p[LATENCY] & bus.cdb_grant;
  assign bus.bc_label  = vld_p[LATENCY] ? lbl_p[LATENCY]  : '0;
  assign bus.bc_data   = vld_p[LATENCY] ? data_p[LATENCY] : '0;
  assign bus.bc_err    = vld_p[LATENCY] & err_p[LATENCY];
  assign bus.exe_able  = take[1];
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed issue vectors, stalls, label-0 drops and mid-flight reset.
module tb_exec_unit;
  import exec_unit_pkg::*;

  localparam int LAT = 2;

`ifdef EXEC_MUL_EN
  localparam logic        MUL_ERR = 1'b0;
  localparam logic [31:0] MUL35   = 32'd15;
`else
  localparam logic        MUL_ERR = 1'b1;
  localparam logic [31:0] MUL35   = 32'd0;
`endif

  typedef struct packed {
    logic [4:0]  lbl;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  lbl;
    logic [31:0] d;
    logic        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   bc_count = 0;
  exp_t sb[$];
  vec_t tbl[$];

  exec_unit_if bus();

  exec_unit #(.LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] lbl);
    bus.issue_en    = 1'b1;
    bus.issue_op    = op;
    bus.issue_data1 = a;
    bus.issue_data2 = b;
    bus.issue_label = lbl;
  endtask

  task automatic push_exp(input logic [4:0] lbl, input logic [31:0] d, input logic e);
    exp_t x;
    x.lbl  = lbl;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every broadcast must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.bc_en) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bc actual_label=%0d required=no_broadcast", bus.bc_label);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("bc_label", 64'(bus.bc_label), 64'(e.lbl));
          chk("bc_data",  64'(bus.bc_data),  64'(e.data));
          chk("bc_err",   64'(bus.bc_err),   64'(e.err));
          bc_count++;
        end
      end
      if (!bus.cdb_req)
        chk("idle_zero", 64'({bus.bc_en, bus.bc_err, bus.bc_label, bus.bc_data}), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int n;
    int occ_before;
    logic [31:0] held;

    tbl.push_back('{5'd1,  32'h0,        32'h1,        5'd1,  32'hFFFFFFFF, 1'b0});
    tbl.push_back('{5'd7,  32'hFFFFFFFF, 32'h2,        5'd2,  32'h1,        1'b0});
    tbl.push_back('{5'd6,  32'h80000000, 32'd31,       5'd4,  32'h1,        1'b0});
    tbl.push_back('{5'd2,  32'hF0F0,     32'hFF00,     5'd5,  32'hF000,     1'b0});
    tbl.push_back('{5'd3,  32'h0F,       32'hF0,       5'd6,  32'hFF,       1'b0});
    tbl.push_back('{5'd4,  32'hFF,       32'h0F,       5'd7,  32'hF0,       1'b0});
    tbl.push_back('{5'd5,  32'h1,        32'd4,        5'd8,  32'h10,       1'b0});
    tbl.push_back('{5'd0,  32'hFFFFFFFF, 32'h2,        5'd9,  32'h1,        1'b0});
    tbl.push_back('{5'd7,  32'h2,        32'hFFFFFFFF, 5'd10, 32'h0,        1'b0});
    tbl.push_back('{5'd6,  32'h8,        32'd33,       5'd11, 32'h4,        1'b0});
    tbl.push_back('{5'd8,  32'h10000,    32'h10000,    5'd12, 32'h0,        MUL_ERR});
    tbl.push_back('{5'd8,  32'h3,        32'h5,        5'd13, MUL35,        MUL_ERR});
    tbl.push_back('{5'd31, 32'h7,        32'h7,        5'd14, 32'h0,        1'b1});
    tbl.push_back('{5'd9,  32'h1,        32'h1,        5'd15, 32'h0,        1'b1});

    rst_n           = 1'b0;
    bus.issue_en    = 1'b0;
    bus.issue_op    = '0;
    bus.issue_data1 = '0;
    bus.issue_data2 = '0;
    bus.issue_label = '0;
    bus.cdb_grant   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cdb_req",   64'(bus.cdb_req),   64'd0);
    chk("rst_bc_en",     64'(bus.bc_en),     64'd0);
    chk("rst_bc_label",  64'(bus.bc_label),  64'd0);
    chk("rst_bc_data",   64'(bus.bc_data),   64'd0);
    chk("rst_bc_err",    64'(bus.bc_err),    64'd0);
    chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
    chk("rst_exe_able",  64'(bus.exe_able),  64'd1);
    step();
    rst_n = 1'b1;
    bus.cdb_grant = 1'b1;
    step();

    // ADD 5+7 with continuous grant: latency measured from the issue edge
    drive_issue(OP_ADD, 32'd5, 32'd7, 5'd3);
    push_exp(5'd3, 32'd12, 1'b0);
    step();
    bus.issue_en = 1'b0;
    got = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.bc_en) begin
        got = c;
        break;
      end
    end
    chk("add_latency", 64'(got), 64'(LAT));
    @(negedge clk);
    chk("add_one_cycle", 64'(bus.bc_en), 64'd0);
    step();

    // Back-to-back directed vectors
    foreach (tbl[k]) begin
      drive_issue(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].lbl);
      push_exp(tbl[k].lbl, tbl[k].d, tbl[k].e);
      step();
    end
    bus.issue_en = 1'b0;
    repeat (LAT + 3) step();
    chk("tbl_drain", 64'(sb.size()), 64'd0);

    // Stall: fill with grant low, then one grant pulse with a simultaneous issue
    bus.cdb_grant = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      drive_issue(OP_ADD, 32'(100 + k), 32'd1, 5'(16 + k));
      push_exp(5'(16 + k), 32'(101 + k), 1'b0);
      step();
    end
    bus.issue_en = 1'b0;
    @(negedge clk);
    chk("stall_exe_able",  64'(bus.exe_able),  64'd0);
    chk("stall_occupancy", 64'(bus.occupancy), 64'(LAT));
    chk("stall_head",      64'(bus.bc_label),  64'd16);
    held = bus.bc_data;
    repeat (2) @(negedge clk);
    chk("stall_hold", 64'(bus.bc_data), 64'(held));
    chk("stall_hold_data", 64'(bus.bc_data), 64'd101);
    step();
    bus.cdb_grant = 1'b1;
    drive_issue(OP_ADD, 32'd1, 32'd1, 5'd30);
    push_exp(5'd30, 32'd2, 1'b0);
    @(negedge clk);
    chk("grant_exe_able", 64'(bus.exe_able), 64'd1);
    chk("grant_bc_en",    64'(bus.bc_en),    64'd1);
    step();
    bus.issue_en  = 1'b0;
    bus.cdb_grant = 1'b0;
    @(negedge clk);
    chk("refill_occupancy", 64'(bus.occupancy), 64'(LAT));
    step();
    bus.cdb_grant = 1'b1;
    repeat (LAT + 3) step();
    chk("stall_drain", 64'(sb.size()), 64'd0);

    // Label 0 is never accepted
    occ_before = int'(bus.occupancy);
    drive_issue(OP_ADD, 32'd1, 32'd2, 5'd0);
    step();
    bus.issue_en = 1'b0;
    @(negedge clk);
    chk("lbl0_occupancy", 64'(bus.occupancy), 64'(occ_before));
    repeat (LAT + 1) @(negedge clk);
    chk("lbl0_cdb_req", 64'(bus.cdb_req), 64'd0);
    step();

    // Reset with entries in flight: everything discarded
    bus.cdb_grant = 1'b0;
    n = (LAT >= 2) ? 2 : 1;
    for (int k = 0; k < n; k++) begin
      drive_issue(OP_XOR, 32'hA5A5, 32'(k), 5'(24 + k));
      step();
    end
    bus.issue_en = 1'b0;
    chk("prerst_occupancy", 64'(bus.occupancy), 64'(n));
    chk("prerst_cdb_req",   64'(bus.cdb_req),   64'(n == LAT));
    rst_n = 1'b0;
    #1;
    chk("midrst_cdb_req",   64'(bus.cdb_req),   64'd0);
    chk("midrst_occupancy", 64'(bus.occupancy), 64'd0);
    chk("midrst_bc_label",  64'(bus.bc_label),  64'd0);
    chk("midrst_bc_data",   64'(bus.bc_data),   64'd0);
    chk("midrst_exe_able",  64'(bus.exe_able),  64'd1);
    got = bc_count;
    step();
    rst_n = 1'b1;
    bus.cdb_grant = 1'b1;
    repeat (LAT + 4) step();
    chk("postrst_no_bc", 64'(bc_count), 64'(got));
    chk("final_drain",   64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
